prbs_err_monitor: RTL and testbench

- Sits directly downstream of a PRBS checker instance with NBITS-wide input.
- Consumes the checker's per-bit error vector on each checked word, together with the checker enable.
- Runs a lock/loss-of-sync state machine.
- While locked, accumulates saturating bit-error, errored-word and total-word counts plus a loss-of-lock event count for BER measurement.

---
 rtl/prbs_mon_pkg.sv | 34 +++
 rtl/prbs_err_popcnt.sv | 32 +++
 rtl/prbs_err_monitor.sv | 133 +++++++++++++
 tb/tb_prbs_err_monitor.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/prbs_mon_pkg.sv
// Shared types and helpers for the PRBS error monitor: FSM state encoding,
// error-vector popcount and a width-bounded saturating adder.
package prbs_mon_pkg;

  localparam int unsigned MAX_NBITS = 32;
  localparam int unsigned POP_MAX_W = 6;

  typedef enum logic {
    ST_HUNT   = 1'b0,
    ST_LOCKED = 1'b1
  } mon_state_e;

  function automatic logic [POP_MAX_W-1:0] popcount(input logic [MAX_NBITS-1:0] v);
    logic [POP_MAX_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_NBITS; i++) begin
      n = n + {{(POP_MAX_W-1){1'b0}}, v[i]};
    end
    return n;
  endfunction

  // Clamps a + b to the all-ones value of a w-bit counter (w <= 62, so the
  // 64-bit sum of two in-range operands cannot itself overflow).
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int unsigned w);
    logic [63:0] lim;
    logic [63:0] sum;
    lim = (64'd1 << w) - 64'd1;
    sum = a + b;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/prbs_err_popcnt.sv
// Stage 1: registers word-valid, error-bit popcount and any-error flag for
// each checked word; the error vector is only sampled when it is valid.
module prbs_err_popcnt
  import prbs_mon_pkg::*;
#(
  parameter int NBITS = 8,
  parameter int POP_W = $clog2(NBITS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] err_vec,
  input  logic             err_vld,
  output logic             s1_vld,
  output logic [POP_W-1:0] s1_pop,
  output logic             s1_bad
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld <= 1'b0;
      s1_pop <= '0;
      s1_bad <= 1'b0;
    end else begin
      s1_vld <= err_vld;
      if (err_vld) begin
        s1_pop <= POP_W'(popcount(MAX_NBITS'(err_vec)));
        s1_bad <= |err_vec;
      end
    end
  end

endmodule

// File: rtl/prbs_err_monitor.sv
// PRBS error monitor: lock/loss-of-sync FSM plus saturating BER counters fed
// by a registered popcount stage; outputs settle two edges after a word.
module prbs_err_monitor
  import prbs_mon_pkg::*;
#(
  parameter int NBITS      = 8,
  parameter int CNT_W      = 32,
  parameter int LOSS_CNT_W = 16,
  parameter int LOCK_GOOD  = 16,
  parameter int LOSS_BAD   = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NBITS-1:0]      ERR_VEC,
  input  logic                  ERR_VLD,
  input  logic                  CLR,
  output logic                  LOCKED,
  output logic                  ERR_DETECT,
  output logic [CNT_W-1:0]      BIT_ERR_CNT,
  output logic [CNT_W-1:0]      ERR_WORD_CNT,
  output logic [CNT_W-1:0]      WORD_CNT,
  output logic [LOSS_CNT_W-1:0] LOSS_CNT
);

  localparam int POP_W = $clog2(NBITS + 1);
  localparam int GR_W  = $clog2(LOCK_GOOD + 1);
  localparam int BR_W  = $clog2(LOSS_BAD + 1);

  logic             s1_vld;
  logic [POP_W-1:0] s1_pop;
  logic             s1_bad;

  mon_state_e       state, state_nxt;
  logic [GR_W-1:0]  good_run, good_nxt;
  logic [BR_W-1:0]  bad_run, bad_nxt;
  logic             count_word;
  logic             loss_evt;

  prbs_err_popcnt #(
    .NBITS (NBITS),
    .POP_W (POP_W)
  ) u_popcnt (
    .clk     (CLK),
    .rst_n   (RST_N),
    .err_vec (ERR_VEC),
    .err_vld (ERR_VLD),
    .s1_vld  (s1_vld),
    .s1_pop  (s1_pop),
    .s1_bad  (s1_bad)
  );

  // ---- stage 2: sync FSM evaluation of the stage-1 word ----
  always_comb begin
    state_nxt  = state;
    good_nxt   = good_run;
    bad_nxt    = bad_run;
    count_word = 1'b0;
    loss_evt   = 1'b0;
    if (s1_vld) begin
      case (state)
        ST_HUNT: begin
          if (s1_bad) begin
            good_nxt = '0;
          end else if ((good_run + 1'b1) == GR_W'(LOCK_GOOD)) begin
            state_nxt = ST_LOCKED;
            good_nxt  = '0;
            bad_nxt   = '0;
          end else begin
            good_nxt = good_run + 1'b1;
          end
        end
        ST_LOCKED: begin
          count_word = 1'b1;
          if (!s1_bad) begin
            bad_nxt = '0;
          end else if ((bad_run + 1'b1) == BR_W'(LOSS_BAD)) begin
            state_nxt = ST_HUNT;
            good_nxt  = '0;
            bad_nxt   = '0;
            loss_evt  = 1'b1;
          end else begin
            bad_nxt = bad_run + 1'b1;
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= ST_HUNT;
      good_run <= '0;
      bad_run  <= '0;
    end else begin
      state    <= state_nxt;
      good_run <= good_nxt;
      bad_run  <= bad_nxt;
    end
  end

  assign LOCKED = (state == ST_LOCKED);

  // CLR wins over a coincident counted word or loss event; the FSM is untouched.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      BIT_ERR_CNT  <= '0;
      ERR_WORD_CNT <= '0;
      WORD_CNT     <= '0;
      LOSS_CNT     <= '0;
      ERR_DETECT   <= 1'b0;
    end else if (CLR) begin
      BIT_ERR_CNT  <= '0;
      ERR_WORD_CNT <= '0;
      WORD_CNT     <= '0;
      LOSS_CNT     <= '0;
      ERR_DETECT   <= 1'b0;
    end else begin
      if (count_word) begin
        WORD_CNT    <= CNT_W'(sat_add(64'(WORD_CNT), 64'd1, CNT_W));
        BIT_ERR_CNT <= CNT_W'(sat_add(64'(BIT_ERR_CNT), 64'(s1_pop), CNT_W));
        if (s1_bad) begin
          ERR_WORD_CNT <= CNT_W'(sat_add(64'(ERR_WORD_CNT), 64'd1, CNT_W));
          ERR_DETECT   <= 1'b1;
        end
      end
      if (loss_evt) begin
        LOSS_CNT <= LOSS_CNT_W'(sat_add(64'(LOSS_CNT), 64'd1, LOSS_CNT_W));
      end
    end
  end

endmodule

// File: tb/tb_prbs_err_monitor.sv
// Directed bench for prbs_err_monitor: a default-width instance and a 4-bit
// counter instance share one stimulus stream.
module tb_prbs_err_monitor;

  logic        CLK;
  logic        RST_N;
  logic [7:0]  ERR_VEC;
  logic        ERR_VLD;
  logic        CLR;

  logic        LOCKED, ERR_DETECT;
  logic [31:0] BIT_ERR_CNT, ERR_WORD_CNT, WORD_CNT;
  logic [15:0] LOSS_CNT;

  logic        LOCKED4, ERR_DETECT4;
  logic [3:0]  BIT_ERR_CNT4, ERR_WORD_CNT4, WORD_CNT4;
  logic [15:0] LOSS_CNT4;

  int checks = 0;
  int errors = 0;

  prbs_err_monitor dut (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .ERR_VEC      (ERR_VEC),
    .ERR_VLD      (ERR_VLD),
    .CLR          (CLR),
    .LOCKED       (LOCKED),
    .ERR_DETECT   (ERR_DETECT),
    .BIT_ERR_CNT  (BIT_ERR_CNT),
    .ERR_WORD_CNT (ERR_WORD_CNT),
    .WORD_CNT     (WORD_CNT),
    .LOSS_CNT     (LOSS_CNT)
  );

  prbs_err_monitor #(.CNT_W(4)) dut4 (
    .CLK          (CLK),
    .RST_N        (RST_N),
    .ERR_VEC      (ERR_VEC),
    .ERR_VLD      (ERR_VLD),
    .CLR          (CLR),
    .LOCKED       (LOCKED4),
    .ERR_DETECT   (ERR_DETECT4),
    .BIT_ERR_CNT  (BIT_ERR_CNT4),
    .ERR_WORD_CNT (ERR_WORD_CNT4),
    .WORD_CNT     (WORD_CNT4),
    .LOSS_CNT     (LOSS_CNT4)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] v);
    ERR_VEC = v;
    ERR_VLD = 1'b1;
    @(negedge CLK);
    ERR_VLD = 1'b0;
    ERR_VEC = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge CLK);
  endtask

  initial begin
    RST_N   = 1'b0;
    ERR_VEC = 8'h00;
    ERR_VLD = 1'b0;
    CLR     = 1'b0;
    idle(2);
    chk("rst_locked", 64'(LOCKED), 64'(0));
    chk("rst_bit", 64'(BIT_ERR_CNT), 64'(0));
    chk("rst_word", 64'(WORD_CNT), 64'(0));
    chk("rst_loss", 64'(LOSS_CNT), 64'(0));
    chk("rst_det", 64'(ERR_DETECT), 64'(0));
    RST_N = 1'b1;
    idle(1);

    // Lock acquisition after 16 clean words, latency 2
    for (int i = 0; i < 15; i++) send(8'h00);
    idle(2);
    chk("t1_not_locked_15", 64'(LOCKED), 64'(0));
    send(8'h00);
    chk("t1_latency", 64'(LOCKED), 64'(0));
    idle(1);
    chk("t1_locked", 64'(LOCKED), 64'(1));
    chk("t1_word", 64'(WORD_CNT), 64'(0));
    chk("t1_bit", 64'(BIT_ERR_CNT), 64'(0));
    chk("t1_det", 64'(ERR_DETECT), 64'(0));

    // Single errored word 0000_0101
    send(8'b0000_0101);
    idle(2);
    chk("t2_bit", 64'(BIT_ERR_CNT), 64'(2));
    chk("t2_ewc", 64'(ERR_WORD_CNT), 64'(1));
    chk("t2_word", 64'(WORD_CNT), 64'(1));
    chk("t2_det", 64'(ERR_DETECT), 64'(1));
    for (int i = 0; i < 3; i++) send(8'h00);
    idle(2);
    chk("t2_det_sticky", 64'(ERR_DETECT), 64'(1));
    chk("t2_word4", 64'(WORD_CNT), 64'(4));

    // Idle CLR zeroes counters, keeps lock
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("clr_bit", 64'(BIT_ERR_CNT), 64'(0));
    chk("clr_word", 64'(WORD_CNT), 64'(0));
    chk("clr_det", 64'(ERR_DETECT), 64'(0));
    chk("clr_locked", 64'(LOCKED), 64'(1));

    // Three bad + one clean keeps lock; four bad drops it
    for (int i = 0; i < 3; i++) send(8'hFF);
    send(8'h00);
    idle(2);
    chk("t3_locked", 64'(LOCKED), 64'(1));
    chk("t3_bit24", 64'(BIT_ERR_CNT), 64'(24));
    chk("t3_ewc3", 64'(ERR_WORD_CNT), 64'(3));
    for (int i = 0; i < 4; i++) send(8'hFF);
    idle(2);
    chk("t3_unlocked", 64'(LOCKED), 64'(0));
    chk("t3_loss", 64'(LOSS_CNT), 64'(1));
    chk("t3_bit56", 64'(BIT_ERR_CNT), 64'(56));
    chk("t3_ewc7", 64'(ERR_WORD_CNT), 64'(7));
    chk("t3_word8", 64'(WORD_CNT), 64'(8));

    // CLR on the stage-2 edge of the lock-completing word
    for (int i = 0; i < 15; i++) send(8'h00);
    send(8'h00);
    CLR = 1'b1;
    @(negedge CLK);
    CLR = 1'b0;
    chk("t5_locked", 64'(LOCKED), 64'(1));
    chk("t5_bit", 64'(BIT_ERR_CNT), 64'(0));
    chk("t5_ewc", 64'(ERR_WORD_CNT), 64'(0));
    chk("t5_word", 64'(WORD_CNT), 64'(0));
    chk("t5_loss", 64'(LOSS_CNT), 64'(0));
    chk("t5_det", 64'(ERR_DETECT), 64'(0));

    // Async reset mid-cycle with a word in flight
    send(8'hFF);
    idle(2);
    chk("t6_pre_bit", 64'(BIT_ERR_CNT), 64'(8));
    send(8'hFF);
    #2 RST_N = 1'b0;
    #1;
    chk("t6_rst_locked", 64'(LOCKED), 64'(0));
    chk("t6_rst_bit", 64'(BIT_ERR_CNT), 64'(0));
    chk("t6_rst_ewc", 64'(ERR_WORD_CNT), 64'(0));
    chk("t6_rst_word", 64'(WORD_CNT), 64'(0));
    chk("t6_rst_det", 64'(ERR_DETECT), 64'(0));
    chk("t6_rst_bit4", 64'(BIT_ERR_CNT4), 64'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    idle(2);
    chk("t6_discard", 64'(BIT_ERR_CNT), 64'(0));
    for (int i = 0; i < 15; i++) send(8'h00);
    idle(2);
    chk("t6_relock_15", 64'(LOCKED), 64'(0));
    send(8'h00);
    idle(2);
    chk("t6_relock_16", 64'(LOCKED), 64'(1));

    // Saturation on the 4-bit instance
    for (int i = 0; i < 10; i++) begin
      send(8'hFF);
      send(8'h00);
    end
    idle(2);
    chk("t4_bit_sat", 64'(BIT_ERR_CNT4), 64'(15));
    chk("t4_ewc10", 64'(ERR_WORD_CNT4), 64'(10));
    chk("t4_word_sat", 64'(WORD_CNT4), 64'(15));
    chk("t4_locked", 64'(LOCKED4), 64'(1));
    chk("t4_wide_bit", 64'(BIT_ERR_CNT), 64'(80));
    for (int i = 0; i < 6; i++) begin
      send(8'hFF);
      send(8'h00);
    end
    idle(2);
    chk("t4_ewc_sat", 64'(ERR_WORD_CNT4), 64'(15));
    chk("t4_bit_hold", 64'(BIT_ERR_CNT4), 64'(15));
    chk("t4_word_hold", 64'(WORD_CNT4), 64'(15));
    chk("t4_wide_ewc", 64'(ERR_WORD_CNT), 64'(16));
    chk("t4_wide_word", 64'(WORD_CNT), 64'(32));
    chk("t4_wide_bit128", 64'(BIT_ERR_CNT), 64'(128));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
